// File: rtl/ls_seq_pkg.sv
// Shared definitions for the load/store sequencer: state encoding, access
// size codes, wait-counter width and small decode helpers.
package ls_seq_pkg;

  // Wide enough for the largest memory latency (15 cycles)
  localparam int WAIT_W = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    LD_MDR   = 3'd2,
    LD_WB    = 3'd3,
    ST_MDR   = 3'd4,
    ST_WRITE = 3'd5
  } ls_state_t;

  // Size code 11 behaves exactly like a word access
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SIZE_WORD : s;
  endfunction

  // Half needs an even address, word needs a 4-byte aligned address
  function automatic logic misaligned(input logic [1:0] s, input logic [1:0] a);
    logic [1:0] ns;
    ns = norm_size(s);
    if (ns == SIZE_HALF) return a[0];
    if (ns == SIZE_WORD) return (a != 2'b00);
    return 1'b0;
  endfunction

endpackage

// File: rtl/ls_wait_counter.sv
// Memory-latency down-counter: loaded on entry to the read wait, counts down
// while enabled and flags when it holds zero.
module ls_wait_counter
  import ls_seq_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load takes priority; decrement saturates at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/load_store_sequencer.sv
// Load/store control sequencer. Loads wait MEM_WAIT cycles, capture the MDR
// and write back; word stores write immediately; byte/half stores do a
// read-modify-write. Optional alignment check: define LS_ALIGN_CHECK_EN.
module load_store_sequencer
  import ls_seq_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_load,
  input  logic       start_store,
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       mem_write,
  output logic       mdr_write,
  output logic       reg_write,
  output logic [1:0] set_load_size_control,
  output logic [1:0] set_store_size_control,
  output logic       busy,
  output logic       done,
  output logic       align_excp
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_WAIT - 1);

  ls_state_t  state, state_nx;
  logic [1:0] size_q;
  logic       is_load_q;
  logic       req, reject, accept;
  logic       cnt_load, wait_zero;

  assign req = start_load | start_store;

`ifdef LS_ALIGN_CHECK_EN
  logic align_q;
  assign reject = (state == IDLE) && req && misaligned(size, addr_lo);

  // One-cycle pulse for each rejected misaligned request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) align_q <= 1'b0;
    else       align_q <= reject;
  end

  assign align_excp = align_q;
`else
  logic unused_addr;
  assign unused_addr = ^addr_lo;
  assign reject      = 1'b0;
  assign align_excp  = 1'b0;
`endif

  assign accept = (state == IDLE) && req && !reject;

  // Counter is loaded only on the transition into the read wait
  assign cnt_load = (state == IDLE) && (state_nx == RD_WAIT);

  ls_wait_counter #(.W(WAIT_W)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (state == RD_WAIT),
    .load_val (WAIT_INIT),
    .zero     (wait_zero)
  );

  // State register plus the request attributes captured at acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      size_q    <= SIZE_BYTE;
      is_load_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        size_q    <= norm_size(size);
        is_load_q <= start_load;
      end
    end
  end

  // Next-state and strobe decode; load wins over a simultaneous store
  always_comb begin
    state_nx  = state;
    mem_write = 1'b0;
    mdr_write = 1'b0;
    reg_write = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (start_load)                         state_nx = RD_WAIT;
          else if (norm_size(size) == SIZE_WORD)  state_nx = ST_WRITE;
          else                                    state_nx = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (wait_zero) state_nx = is_load_q ? LD_MDR : ST_MDR;
      end
      LD_MDR: begin
        mdr_write = 1'b1;
        state_nx  = LD_WB;
      end
      LD_WB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_nx  = IDLE;
      end
      ST_MDR: begin
        mdr_write = 1'b1;
        state_nx  = ST_WRITE;
      end
      ST_WRITE: begin
        mem_write = 1'b1;
        done      = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy                   = (state != IDLE);
  assign set_load_size_control  = size_q;
  assign set_store_size_control = size_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Bench for load_store_sequencer: two instances (MEM_WAIT=1 and 3) share the
// stimulus; a transaction-level model predicts every output each cycle.
module tb_load_store_sequencer;

`ifdef LS_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_load = 1'b0, start_store = 1'b0;
  logic [1:0] size = 2'b00, addr_lo = 2'b00;

  logic       mem_write[2], mdr_write[2], reg_write[2];
  logic       busy[2], done[2], align_excp[2];
  logic [1:0] lsc[2], ssc[2];

  always #5 clk = ~clk;

  load_store_sequencer #(.MEM_WAIT(1)) u_a (
    .clk(clk), .reset(reset), .start_load(start_load), .start_store(start_store),
    .size(size), .addr_lo(addr_lo), .mem_write(mem_write[0]), .mdr_write(mdr_write[0]),
    .reg_write(reg_write[0]), .set_load_size_control(lsc[0]),
    .set_store_size_control(ssc[0]), .busy(busy[0]), .done(done[0]),
    .align_excp(align_excp[0]));

  load_store_sequencer #(.MEM_WAIT(3)) u_b (
    .clk(clk), .reset(reset), .start_load(start_load), .start_store(start_store),
    .size(size), .addr_lo(addr_lo), .mem_write(mem_write[1]), .mdr_write(mdr_write[1]),
    .reg_write(reg_write[1]), .set_load_size_control(lsc[1]),
    .set_store_size_control(ssc[1]), .busy(busy[1]), .done(done[1]),
    .align_excp(align_excp[1]));

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // kind: 0 load, 1 word store, 2 read-modify-write store
  function automatic int mw_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit bad_align(input logic [1:0] s, input logic [1:0] a);
    bit r;
    r = 1'b0;
    if (s == 2'b01 && a[0]) r = 1'b1;
    if (s[1] && a != 2'b00) r = 1'b1;
    return ALIGN_EN && r;
  endfunction

  bit       act[2];
  int       k[2], len[2], kind[2];
  bit [1:0] msz[2];
  bit       aexp[2];
  bit       was_idle;

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        act[i] = 1'b0; k[i] = 0; msz[i] = 2'b00; aexp[i] = 1'b0;
      end else begin
        was_idle = !act[i];
        if (act[i]) begin
          if (k[i] == len[i]) act[i] = 1'b0;
          else k[i] = k[i] + 1;
        end
        aexp[i] = 1'b0;
        if (was_idle && (start_load || start_store)) begin
          if (bad_align(size, addr_lo)) begin
            aexp[i] = 1'b1;
          end else begin
            act[i] = 1'b1;
            k[i]   = 1;
            msz[i] = (size == 2'b11) ? 2'b10 : size;
            if (start_load)          begin kind[i] = 0; len[i] = mw_of(i) + 2; end
            else if (msz[i] == 2'b10) begin kind[i] = 1; len[i] = 1; end
            else                      begin kind[i] = 2; len[i] = mw_of(i) + 2; end
          end
        end
      end
    end
  end

  int memcnt[2], donecnt[2];

  // Compare every output of both instances on each falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int m;
      m = mw_of(i);
      chk($sformatf("busy[%0d]", i), busy[i], act[i]);
      chk($sformatf("mdr[%0d]", i), mdr_write[i], act[i] && kind[i] != 1 && k[i] == m + 1);
      chk($sformatf("reg[%0d]", i), reg_write[i], act[i] && kind[i] == 0 && k[i] == m + 2);
      chk($sformatf("mem[%0d]", i), mem_write[i],
          act[i] && ((kind[i] == 1 && k[i] == 1) || (kind[i] == 2 && k[i] == m + 2)));
      chk($sformatf("done[%0d]", i), done[i], act[i] && k[i] == len[i]);
      chk($sformatf("lsc[%0d]", i), lsc[i], msz[i]);
      chk($sformatf("ssc[%0d]", i), ssc[i], msz[i]);
      chk($sformatf("align[%0d]", i), align_excp[i], aexp[i]);
      chk($sformatf("excl[%0d]", i),
          32'(mem_write[i]) + 32'(mdr_write[i]) + 32'(reg_write[i]) <= 1, 1);
      if (mem_write[i] === 1'b1) memcnt[i]++;
      if (done[i] === 1'b1) donecnt[i]++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit sl, input bit ss, input logic [1:0] sz, input logic [1:0] al);
    @(posedge clk);
    #1;
    start_load = sl; start_store = ss; size = sz; addr_lo = al;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  int mb[2], db[2];

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_busy_a", busy[0], 0);
    chk("rst_lsc_b", lsc[1], 0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // byte load: A (MEM_WAIT=1) mdr at cycle 2, reg/done at cycle 3
    drive(1, 0, 2'b00, 2'b00);
    idle(1); @(negedge clk);
    chk("ld_c1_mdr_a", mdr_write[0], 0);
    chk("ld_c1_busy_a", busy[0], 1);
    idle(1); @(negedge clk);
    chk("ld_c2_mdr_a", mdr_write[0], 1);
    idle(1); @(negedge clk);
    chk("ld_c3_reg_a", reg_write[0], 1);
    chk("ld_c3_done_a", done[0], 1);
    chk("ld_c3_lsc_a", lsc[0], 2'b00);
    idle(6);

    // half store: B (MEM_WAIT=3) mdr at cycle 4, mem/done at cycle 5
    drive(0, 1, 2'b01, 2'b00);
    idle(3);
    idle(1); @(negedge clk);
    chk("st_c4_mdr_b", mdr_write[1], 1);
    chk("st_c4_ssc_b", ssc[1], 2'b01);
    idle(1); @(negedge clk);
    chk("st_c5_mem_b", mem_write[1], 1);
    chk("st_c5_done_b", done[1], 1);
    idle(3);

    // word store: mem/done at cycle 1
    drive(0, 1, 2'b10, 2'b00);
    idle(1); @(negedge clk);
    chk("wst_c1_mem_a", mem_write[0], 1);
    chk("wst_c1_mem_b", mem_write[1], 1);
    chk("wst_c1_done_b", done[1], 1);
    idle(3);

    // simultaneous start: load only
    mb = memcnt; db = donecnt;
    drive(1, 1, 2'b10, 2'b00);
    idle(7);
    chk("both_mem_a", memcnt[0] - mb[0], 0);
    chk("both_mem_b", memcnt[1] - mb[1], 0);
    chk("both_done_b", donecnt[1] - db[1], 1);
    chk("both_lsc_b", lsc[1], 2'b10);

    // size 11 load with store requests pulsed while busy
    db = donecnt;
    drive(1, 0, 2'b11, 2'b00);
    repeat (5) drive(0, 1, 2'b00, 2'b00);
    idle(10);
    chk("busy_done_b", donecnt[1] - db[1], 1);
    chk("busy_done_a", donecnt[0] - db[0], 2);
    chk("sz11_lsc_b", lsc[1], 2'b10);

    // reset during the read wait of a byte store
    drive(0, 1, 2'b00, 2'b00);
    idle(2);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_busy_b", busy[1], 0);
    chk("rstmid_mdr_a", mdr_write[0], 0);
    chk("rstmid_ssc_b", ssc[1], 0);
    chk("rstmid_mem_b", mem_write[1], 0);
    @(posedge clk);
    #1 reset = 1'b0;
    mb = memcnt;
    idle(10);
    chk("rstmid_nomem_a", memcnt[0] - mb[0], 0);
    chk("rstmid_nomem_b", memcnt[1] - mb[1], 0);

    // alignment: word load at addr_lo=10, then aligned word load
    drive(1, 0, 2'b10, 2'b10);
    idle(1); @(negedge clk);
    chk("al_bad_align_b", align_excp[1], ALIGN_EN);
    chk("al_bad_busy_b", busy[1], !ALIGN_EN);
    idle(6);
    drive(1, 0, 2'b10, 2'b00);
    idle(1); @(negedge clk);
    chk("al_ok_align_b", align_excp[1], 0);
    chk("al_ok_busy_b", busy[1], 1);
    idle(6);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
